nrf_spi_responder: RTL and testbench



---
 rtl/nrf_spi_responder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_nrf_spi_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrf_spi_responder.sv
// nRF24L01 SPI command-interface responder for RF-less loopback bring-up.
// Oversamples csn/sck/mosi on clk_10 and answers with STATUS, register and payload data.
module nrf_spi_responder (
  input  logic       clk_10,
  input  logic       rst,
  input  logic       csn,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic [5:0] payload_count,
  output logic       cmd_done,
  output logic [7:0] last_cmd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_REG_RD,
    S_REG_WR,
    S_PL_RD,
    S_PL_WR,
    S_IGNORE
  } state_e;

  localparam logic [4:0] STATUS_ADDR      = 5'h07;
  localparam logic [5:0] FIFO_DEPTH       = 6'd32;
  localparam logic [7:0] CMD_R_RX_PAYLOAD = 8'h61;
  localparam logic [7:0] CMD_W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] CMD_FLUSH_TX     = 8'hE1;
  localparam logic [7:0] CMD_FLUSH_RX     = 8'hE2;

  function automatic logic [7:0] reg_reset_value(input int unsigned idx);
    case (idx)
      0:       return 8'h08;
      1:       return 8'h3F;
      2:       return 8'h03;
      3:       return 8'h03;
      4:       return 8'h03;
      5:       return 8'h02;
      6:       return 8'h0F;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Pin synchronizers; bit [2] of csn/sck is the edge-detect history flop.
  // ---------------------------------------------------------------------------
  logic [2:0] csn_sync_q;
  logic [2:0] sck_sync_q;
  logic [1:0] mosi_sync_q;

  // csn history resets low so a select held low across reset never looks like a fall.
  always_ff @(posedge clk_10) begin
    if (rst) begin
      csn_sync_q  <= 3'b000;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      csn_sync_q  <= {csn_sync_q[1:0], csn};
      sck_sync_q  <= {sck_sync_q[1:0], sck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  logic csn_fall;
  logic csn_rise;
  logic sck_rise;
  logic sck_fall;
  logic mosi_s;

  assign csn_fall = csn_sync_q[2] & ~csn_sync_q[1];
  assign csn_rise = ~csn_sync_q[2] & csn_sync_q[1];
  assign sck_rise = ~sck_sync_q[2] & sck_sync_q[1];
  assign sck_fall = sck_sync_q[2] & ~sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [4:0] addr_q, addr_d;
  logic       byte_done_q, byte_done_d;
  logic       cmd_seen_q, cmd_seen_d;
  logic [7:0] last_cmd_q, last_cmd_d;
  logic [4:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] wr_ptr_q, wr_ptr_d;
  logic [5:0] count_q, count_d;
  logic [5:0] payload_count_q, payload_count_d;
  logic       cmd_done_q, cmd_done_d;

  logic [7:0] reg_q  [32];
  logic [7:0] fifo_q [32];

  logic       reg_we;
  logic       fifo_we;
  logic [7:0] rx_byte;
  logic [7:0] status;
  logic [7:0] resp_byte;
  logic       fifo_empty;
  logic       fifo_full;

  assign rx_byte    = {rx_sh_q, mosi_s};
  assign fifo_empty = (count_q == 6'd0);
  assign fifo_full  = (count_q == FIFO_DEPTH);
  assign status     = {1'b0, ~fifo_empty, 2'b00, (fifo_empty ? 3'b111 : 3'b000), fifo_full};

  // Byte loaded into tx_sh at the fall following a completed byte.
  always_comb begin
    resp_byte = 8'h00;
    case (state_q)
      S_REG_RD: resp_byte = (addr_q == STATUS_ADDR) ? status : reg_q[addr_q];
      S_PL_RD:  resp_byte = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
      default:  resp_byte = 8'h00;
    endcase
  end

  // NOTE: every signal assigned here gets a default first, otherwise paths that skip
  // an assignment infer latches.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    rx_sh_d         = rx_sh_q;
    tx_sh_d         = tx_sh_q;
    addr_d          = addr_q;
    byte_done_d     = byte_done_q;
    cmd_seen_d      = cmd_seen_q;
    last_cmd_d      = last_cmd_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    payload_count_d = count_q;
    cmd_done_d      = 1'b0;
    reg_we          = 1'b0;
    fifo_we         = 1'b0;

    if (csn_rise) begin
      state_d     = S_IDLE;
      bit_cnt_d   = 3'd0;
      rx_sh_d     = 7'd0;
      tx_sh_d     = 8'h00;
      byte_done_d = 1'b0;
      cmd_done_d  = cmd_seen_q;
      cmd_seen_d  = 1'b0;
    end else if (csn_fall && state_q == S_IDLE) begin
      state_d     = S_CMD;
      bit_cnt_d   = 3'd0;
      rx_sh_d     = 7'd0;
      tx_sh_d     = status;
      byte_done_d = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (sck_rise) begin
        rx_sh_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_d = 1'b1;
          case (state_q)
            S_CMD: begin
              last_cmd_d = rx_byte;
              cmd_seen_d = 1'b1;
              addr_d     = rx_byte[4:0];
              if (rx_byte[7:5] == 3'b000) begin
                state_d = S_REG_RD;
              end else if (rx_byte[7:5] == 3'b001) begin
                state_d = S_REG_WR;
              end else if (rx_byte == CMD_R_RX_PAYLOAD) begin
                state_d = S_PL_RD;
              end else if (rx_byte == CMD_W_TX_PAYLOAD) begin
                state_d = S_PL_WR;
              end else begin
                state_d = S_IGNORE;
                if (rx_byte == CMD_FLUSH_TX || rx_byte == CMD_FLUSH_RX) begin
                  rd_ptr_d = 5'd0;
                  wr_ptr_d = 5'd0;
                  count_d  = 6'd0;
                end
              end
            end
            S_REG_RD: addr_d = addr_q + 5'd1;
            S_REG_WR: begin
              reg_we = (addr_q != STATUS_ADDR);
              addr_d = addr_q + 5'd1;
            end
            S_PL_WR: begin
              if (!fifo_full) begin
                fifo_we  = 1'b1;
                wr_ptr_d = wr_ptr_q + 5'd1;
                count_d  = count_q + 6'd1;
              end
            end
            S_PL_RD: begin
              if (!fifo_empty) begin
                rd_ptr_d = rd_ptr_q + 5'd1;
                count_d  = count_q - 6'd1;
              end
            end
            default: ;
          endcase
        end
      end else if (sck_fall) begin
        if (byte_done_q) begin
          tx_sh_d     = resp_byte;
          byte_done_d = 1'b0;
        end else begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_10) begin
    if (rst) begin
      state_q         <= S_IDLE;
      bit_cnt_q       <= 3'd0;
      rx_sh_q         <= 7'd0;
      tx_sh_q         <= 8'h00;
      addr_q          <= 5'd0;
      byte_done_q     <= 1'b0;
      cmd_seen_q      <= 1'b0;
      last_cmd_q      <= 8'h00;
      rd_ptr_q        <= 5'd0;
      wr_ptr_q        <= 5'd0;
      count_q         <= 6'd0;
      payload_count_q <= 6'd0;
      cmd_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_sh_q         <= rx_sh_d;
      tx_sh_q         <= tx_sh_d;
      addr_q          <= addr_d;
      byte_done_q     <= byte_done_d;
      cmd_seen_q      <= cmd_seen_d;
      last_cmd_q      <= last_cmd_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      payload_count_q <= payload_count_d;
      cmd_done_q      <= cmd_done_d;
    end
  end

  // NOTE: the register file has architectural reset values so it is reset; the
  // payload storage is not, because the cleared pointers and count make it unreadable.
  always_ff @(posedge clk_10) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        reg_q[i] <= reg_reset_value(i);
      end
    end else if (reg_we) begin
      reg_q[addr_q] <= rx_byte;
    end
  end

  always_ff @(posedge clk_10) begin
    if (fifo_we) begin
      fifo_q[wr_ptr_q] <= rx_byte;
    end
  end

  assign miso          = (state_q != S_IDLE) & tx_sh_q[7];
  assign payload_count = payload_count_q;
  assign cmd_done      = cmd_done_q;
  assign last_cmd      = last_cmd_q;

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Bench for nrf_spi_responder: an SPI master drives frames, a byte-level nRF24L01 model
// predicts miso bytes and cmd_done results, and monitors compare them as they appear.
module tb_nrf_spi_responder;

  logic       clk_10 = 1'b0;
  logic       rst    = 1'b1;
  logic       csn    = 1'b1;
  logic       sck    = 1'b0;
  logic       mosi   = 1'b0;
  logic       miso;
  logic [5:0] payload_count;
  logic       cmd_done;
  logic [7:0] last_cmd;

  nrf_spi_responder dut (
    .clk_10        (clk_10),
    .rst           (rst),
    .csn           (csn),
    .sck           (sck),
    .mosi          (mosi),
    .miso          (miso),
    .payload_count (payload_count),
    .cmd_done      (cmd_done),
    .last_cmd      (last_cmd)
  );

  always #50 clk_10 = ~clk_10;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: register array and payload queue, updated a byte at a time.
  // ---------------------------------------------------------------------------
  localparam int M_IGN = 0, M_RD = 1, M_WR = 2, M_PRD = 3, M_PWR = 4;

  logic [7:0] regs_m [32];
  logic [7:0] fifo_m [$];
  logic [7:0] exp_miso [$];
  logic [7:0] exp_done_cmd [$];
  int         exp_done_cnt [$];
  logic [7:0] tx_q [$];

  task automatic reset_model();
    for (int i = 0; i < 32; i++) regs_m[i] = 8'h00;
    regs_m[0] = 8'h08; regs_m[1] = 8'h3F; regs_m[2] = 8'h03; regs_m[3] = 8'h03;
    regs_m[4] = 8'h03; regs_m[5] = 8'h02; regs_m[6] = 8'h0F;
    fifo_m.delete();
  endtask

  function automatic logic [7:0] model_status();
    int n = fifo_m.size();
    if (n == 0) return 8'h0E;
    return (n == 32) ? 8'h41 : 8'h40;
  endfunction

  function automatic logic [7:0] model_resp(input int mode, input logic [4:0] addr);
    if (mode == M_RD) return (addr == 5'h07) ? model_status() : regs_m[addr];
    if (mode == M_PRD) return (fifo_m.size() != 0) ? fifo_m[0] : 8'h00;
    return 8'h00;
  endfunction

  // ---------------------------------------------------------------------------
  // SPI master
  // ---------------------------------------------------------------------------
  task automatic send_bit(input logic b);
    mosi = b;
    repeat (6) @(posedge clk_10);
    #7 sck = 1'b1;
    repeat (6) @(posedge clk_10);
    #7 sck = 1'b0;
  endtask

  // Sends tx_q; a nonzero partial_bits sends only that many bits of the last byte.
  task automatic frame(input int partial_bits);
    int         n_full;
    int         mode;
    logic [4:0] addr;
    logic [7:0] b;
    logic [7:0] cmd;
    logic [7:0] resp;
    n_full = tx_q.size() - ((partial_bits > 0) ? 1 : 0);
    mode   = M_IGN;
    addr   = 5'd0;
    cmd    = 8'h00;
    resp   = model_status();
    for (int i = 0; i < n_full; i++) begin
      b = tx_q[i];
      exp_miso.push_back(resp);
      if (i == 0) begin
        cmd  = b;
        addr = b[4:0];
        if (b < 8'h20)       mode = M_RD;
        else if (b < 8'h40)  mode = M_WR;
        else if (b == 8'h61) mode = M_PRD;
        else if (b == 8'hA0) mode = M_PWR;
        else begin
          mode = M_IGN;
          if (b == 8'hE1 || b == 8'hE2) fifo_m.delete();
        end
      end else begin
        case (mode)
          M_RD:  addr = addr + 5'd1;
          M_WR: begin
            if (addr != 5'h07) regs_m[addr] = b;
            addr = addr + 5'd1;
          end
          M_PWR: if (fifo_m.size() < 32) fifo_m.push_back(b);
          M_PRD: if (fifo_m.size() > 0) void'(fifo_m.pop_front());
          default: ;
        endcase
      end
      resp = model_resp(mode, addr);
    end
    if (n_full > 0) begin
      exp_done_cmd.push_back(cmd);
      exp_done_cnt.push_back(fifo_m.size());
    end

    #7 csn = 1'b0;
    for (int i = 0; i < tx_q.size(); i++) begin
      b = tx_q[i];
      for (int k = 0; k < ((i == n_full) ? partial_bits : 8); k++) send_bit(b[7-k]);
    end
    repeat (6) @(posedge clk_10);
    #7 csn = 1'b1;
    repeat (10) @(posedge clk_10);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  initial begin : miso_monitor
    logic [7:0] sh;
    int         nb;
    sh = 8'h00;
    nb = 0;
    forever begin
      @(posedge sck or posedge csn);
      if (csn) begin
        nb = 0;
      end else begin
        sh = {sh[6:0], miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_miso.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL miso_byte: got 0x%0h with no byte expected", sh);
          end else begin
            check("miso_byte", sh, exp_miso.pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk_10) begin
    if (cmd_done) begin
      if (exp_done_cmd.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL cmd_done: got pulse (last_cmd 0x%0h), expected none", last_cmd);
      end else begin
        check("last_cmd", last_cmd, exp_done_cmd.pop_front());
        check("payload_count_at_done", payload_count, exp_done_cnt.pop_front());
      end
    end
  end

  initial begin : watchdog
    #6000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int kind;
    int len;
    reset_model();
    repeat (4) @(posedge clk_10);
    #7 rst = 1'b0;
    repeat (6) @(posedge clk_10);
    @(negedge clk_10);
    check("reset_miso", miso, 0);
    check("reset_payload_count", payload_count, 0);
    check("reset_cmd_done", cmd_done, 0);
    check("reset_last_cmd", last_cmd, 8'h00);
    @(posedge clk_10);

    tx_q = '{8'hFF};                      frame(0);
    tx_q = '{8'h05, 8'h00};               frame(0);
    tx_q = '{8'h25, 8'h4C};               frame(0);
    tx_q = '{8'h05, 8'h00};               frame(0);
    tx_q = '{8'h1F, 8'h00, 8'h00};        frame(0);
    tx_q = '{8'hA0, 8'h11, 8'h22, 8'h33}; frame(0);
    check("payload_count_after_3", payload_count, 3);
    tx_q = '{8'h61, 8'h00, 8'h00, 8'h00}; frame(0);
    tx_q = '{8'hFF};                      frame(0);

    tx_q = '{8'hA0};
    for (int i = 0; i < 34; i++) tx_q.push_back(8'($urandom));
    frame(0);
    check("payload_count_full", payload_count, 32);
    tx_q = '{8'h07, 8'h00};               frame(0);
    tx_q = '{8'hE2};                      frame(0);
    check("payload_count_flushed", payload_count, 0);

    tx_q = '{8'hA0, 8'h5A};               frame(0);
    tx_q = '{8'h61, 8'h00};               frame(4);
    check("payload_count_partial_pop", payload_count, 1);

    // Reset asserted in the middle of a frame with csn still low.
    #7 csn = 1'b0;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    #7 rst = 1'b1;
    repeat (3) @(posedge clk_10);
    #7 rst = 1'b0;
    reset_model();
    repeat (2) @(posedge clk_10);
    @(negedge clk_10);
    check("rst_mid_miso", miso, 0);
    check("rst_mid_payload_count", payload_count, 0);
    check("rst_mid_last_cmd", last_cmd, 8'h00);
    @(posedge clk_10);
    #7 csn = 1'b1;
    repeat (10) @(posedge clk_10);
    tx_q = '{8'h05, 8'h00};               frame(0);

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(0, 4);
      case (kind)
        0: tx_q = '{8'($urandom_range(0, 31))};
        1: tx_q = '{8'(8'h20 + $urandom_range(0, 31))};
        2: tx_q = '{8'hA0};
        3: tx_q = '{8'h61};
        4: tx_q = '{($urandom_range(0, 1) != 0) ? 8'hE1 : 8'hE2};
        default: tx_q = '{8'($urandom)};
      endcase
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
      frame(0);
      check("payload_count_random", payload_count, fifo_m.size());
    end

    repeat (20) @(posedge clk_10);
    check("miso_queue_drained", exp_miso.size(), 0);
    check("cmd_done_queue_drained", exp_done_cmd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
